// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALU op codes, NZCV flag positions and output states.
// Shared by alu and alu_arbiter (build option: ALU_ARB_RR_EN).
package alu_arbiter_pkg;

  localparam int ALU_W      = 32;
  localparam int ALU_CTRL_W = 5;

  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_AND  = 5'h02;
  localparam logic [4:0] ALU_OR   = 5'h03;
  localparam logic [4:0] ALU_XOR  = 5'h04;
  localparam logic [4:0] ALU_SLL  = 5'h05;
  localparam logic [4:0] ALU_SRL  = 5'h06;
  localparam logic [4:0] ALU_SRA  = 5'h07;
  localparam logic [4:0] ALU_SLT  = 5'h08;
  localparam logic [4:0] ALU_SLTU = 5'h09;

  // Highest defined op; anything above is flagged as an error.
  localparam logic [4:0] ALU_OP_LAST = 5'h09;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic logic op_undefined(
    input logic [4:0] c
  );
    return c > ALU_OP_LAST;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: shared 32-bit combinational ALU with NZCV flags.
// C/V come from the single add/sub path (subtract for SUB/SLT/SLTU).
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  ctrl,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic        sub_mode;
  logic [31:0] b_op;
  logic [32:0] sum;
  logic        carry;
  logic        ovf;

  // Adder path, op decode and flag generation
  always_comb begin
    sub_mode = (ctrl == ALU_SUB)
             | (ctrl == ALU_SLT)
             | (ctrl == ALU_SLTU);
    b_op  = sub_mode ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_op}
          + 33'(sub_mode);
    carry = sum[32];
    ovf   = (a[31] == b_op[31])
          & (sum[31] != a[31]);
    case (ctrl)
      ALU_ADD,
      ALU_SUB:  result = sum[31:0];
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_SLT:  result = {31'b0, sum[31] ^ ovf};
      ALU_SLTU: result = {31'b0, ~carry};
      default:  result = '0;
    endcase
    flags          = '0;
    flags[FLAG_N]  = result[31];
    flags[FLAG_Z]  = (result == 32'b0);
    flags[FLAG_C]  = carry;
    flags[FLAG_V]  = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among NUM_REQ requesters, 1-cycle response.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int XLEN    = 32,
  parameter  int CTRL_W  = 5,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*XLEN-1:0]   req_a,
  input  logic [NUM_REQ*XLEN-1:0]   req_b,
  input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [XLEN-1:0]           rsp_result,
  output logic [3:0]                rsp_flags,
  output logic                      rsp_err
);

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_any;
  logic               can_accept;
  logic               accept;
  logic [XLEN-1:0]    sel_a;
  logic [XLEN-1:0]    sel_b;
  logic [CTRL_W-1:0]  sel_ctrl;
  logic [31:0]        alu_result;
  logic [3:0]         alu_flags;
  out_state_e         state;

`ifdef ALU_ARB_RR_EN
  logic [IDW-1:0] rr_ptr;

  function automatic logic [IDW-1:0] wrap_add(
    input logic [IDW-1:0] p,
    input int             k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Round-robin: first valid requester at or after rr_ptr
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_ptr, k)]) begin
        gnt_idx = wrap_add(rr_ptr, k);
        gnt_any = 1'b1;
      end
    end
  end

  // Pointer moves past the winner only on an accept
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= wrap_add(gnt_idx, 1);
    end
  end
`else
  // Fixed priority: lowest valid index wins
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_idx = IDW'(i);
        gnt_any = 1'b1;
      end
    end
  end
`endif

  // One-hot grant from the winning index
  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign can_accept = (state == OUT_EMPTY)
                    | rsp_ready;
  assign accept     = gnt_any & can_accept;
  assign req_ready  = gnt
                    & {NUM_REQ{can_accept}};

  assign sel_a    = req_a[int'(gnt_idx)*XLEN +: XLEN];
  assign sel_b    = req_b[int'(gnt_idx)*XLEN +: XLEN];
  assign sel_ctrl =
    req_ctrl[int'(gnt_idx)*CTRL_W +: CTRL_W];

  alu u_alu (
    .a      (sel_a),
    .b      (sel_b),
    .ctrl   (sel_ctrl),
    .result (alu_result),
    .flags  (alu_flags)
  );

  assign rsp_valid = (state == OUT_FULL);

  // Output register: load on accept, drain on rsp_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= OUT_EMPTY;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (accept) begin
            state      <= OUT_FULL;
            rsp_id     <= gnt_idx;
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= op_undefined(sel_ctrl);
          end
        end
        OUT_FULL: begin
          if (accept) begin
            rsp_id     <= gnt_idx;
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= op_undefined(sel_ctrl);
          end else if (rsp_ready) begin
            state <= OUT_EMPTY;
          end
        end
        default: state <= OUT_EMPTY;
      endcase
    end
  end

endmodule
